// File: rtl/dmem_resp.sv
// Data-memory responder: word RAM plus memory-mapped TX byte FIFO, status and free-running cycle counter.
// Loads are combinational from addr; stores, FIFO pushes/pops and counter updates happen on the rising clk edge.
module dmem_resp #(
  parameter int RAM_AW  = 6,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam int DEPTH     = 1 << FIFO_AW;

  localparam logic [29:0] TXDATA_WA = 30'h3C00_0000;
  localparam logic [29:0] STATUS_WA = 30'h3C00_0001;
  localparam logic [29:0] CYCLE_WA  = 30'h3C00_0002;

  logic [RAM_WORDS-1:0][31:0] ram;
  logic [DEPTH-1:0][7:0]      fifo;
  logic [FIFO_AW-1:0]         rd_ptr, wr_ptr;
  logic [FIFO_AW:0]           count;
  logic                       ovf;
  logic [31:0]                cycle;

  logic              sel_ram, sel_tx, sel_status, sel_cycle;
  logic [RAM_AW-1:0] ram_idx;
  logic              empty, full;
  logic              push, pop, push_ok, drop, clr_ovf;
  logic [31:0]       status_word;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  assign sel_ram    = (addr[31:RAM_AW+2] == '0);
  assign sel_tx     = (addr[31:2] == TXDATA_WA);
  assign sel_status = (addr[31:2] == STATUS_WA);
  assign sel_cycle  = (addr[31:2] == CYCLE_WA);
  assign ram_idx    = addr[RAM_AW+1:2];

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign pop     = out_valid && out_ready;
  assign push    = we && sel_tx;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign clr_ovf = we && sel_status && wdata[2];

  assign status_word = {29'(count), ovf, full, empty};

  // NOTE: every RAM word is cleared by clr, so the array is a reset register file, not an inferred SRAM macro.
  always_ff @(posedge clk) begin
    if (clr) begin
      ram <= '0;
    end else if (we && sel_ram) begin
      ram[ram_idx] <= wdata;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; zeroed pointers and count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (!clr && push_ok) begin
      fifo[wr_ptr] <= wdata[7:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
      // A dropped push wins over a same-cycle clear request.
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cycle <= '0;
    end else if (we && sel_cycle) begin
      cycle <= wdata;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  // NOTE: rdata gets a default before the decode so no path through the block infers a latch.
  always_comb begin
    rdata = '0;
    if (sel_ram)         rdata = ram[ram_idx];
    else if (sel_status) rdata = status_word;
    else if (sel_cycle)  rdata = cycle;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : fifo[rd_ptr];

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: register reads checked inline, TX bytes checked by a queue-based scoreboard.
module tb_dmem_resp;

  localparam logic [31:0] TX  = 32'hF000_0000;
  localparam logic [31:0] ST  = 32'hF000_0004;
  localparam logic [31:0] CYC = 32'hF000_0008;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] addr, wdata, rdata;
  logic        we;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_resp dut (
    .clk       (clk),
    .clr       (clr),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    we    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accept);
    if (accept) exp_q.push_back(b);
    drive(1'b1, TX, {24'h0, b});
    tick();
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, a, 32'h0);
    check(name, rdata, exp);
    tick();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 32'h0, 32'h0);
      tick();
    end
  endtask

  // Scoreboard monitor: head byte compared whenever valid, popped on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (clr === 1'b0 && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%02h expected none", out_data);
        end else begin
          check("out_data", {24'h0, out_data}, {24'h0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; we = 1'b0; addr = '0; wdata = '0; out_ready = 1'b0;
    tick();
    tick();
    clr = 1'b0;

    // Reset state
    drive(1'b0, CYC, 32'h0);
    check("rst_cycle", rdata, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    tick();
    read_chk("rst_status", ST, 32'h1);
    read_chk("rst_ram", 32'h10, 32'h0);

    // RAM write/read
    drive(1'b1, 32'h10, 32'hDEAD_BEEF);
    check("ram_same_cycle_old", rdata, 32'h0);
    tick();
    read_chk("ram_new", 32'h10, 32'hDEAD_BEEF);
    read_chk("ram_byte_offset", 32'h13, 32'hDEAD_BEEF);
    drive(1'b1, 32'h100, 32'h1234_5678);
    check("unmapped_wr_cycle", rdata, 32'h0);
    tick();
    read_chk("unmapped_rd", 32'h100, 32'h0);
    read_chk("no_alias_word0", 32'h0, 32'h0);
    read_chk("txdata_rd", TX, 32'h0);

    // CYCLE load and wrap
    drive(1'b1, CYC, 32'hFFFF_FFFE);
    tick();
    read_chk("cyc_fffe", CYC, 32'hFFFF_FFFE);
    read_chk("cyc_ffff", CYC, 32'hFFFF_FFFF);
    read_chk("cyc_wrap", CYC, 32'h0);
    drive(1'b1, CYC, 32'h10);
    check("cyc_wr_old", rdata, 32'h1);
    tick();
    read_chk("cyc_load", CYC, 32'h10);

    // FIFO order with downstream stalled
    out_ready = 1'b0;
    exp_q.push_back(8'h41);
    drive(1'b1, TX, 32'h41);
    check("push_empty_no_valid", {31'h0, out_valid}, 32'h0);
    check("txdata_wr_rd", rdata, 32'h0);
    tick();
    exp_q.push_back(8'h42);
    drive(1'b1, TX, 32'h42);
    check("valid_latency", {31'h0, out_valid}, 32'h1);
    tick();
    push(8'h43, 1'b1);
    read_chk("status_3", ST, 32'h18);
    out_ready = 1'b1;
    idle_cycles(3);
    drive(1'b0, ST, 32'h0);
    check("drained_valid", {31'h0, out_valid}, 32'h0);
    check("drained_status", rdata, 32'h1);
    tick();

    // No bypass on empty, then push+pop while non-empty
    drive(1'b1, TX, 32'h61);
    exp_q.push_back(8'h61);
    check("no_bypass", {31'h0, out_valid}, 32'h0);
    tick();
    idle_cycles(1);
    push(8'h71, 1'b1);
    push(8'h72, 1'b1);
    idle_cycles(1);
    read_chk("pushpop_drained", ST, 32'h1);

    // Overflow and sticky ovf clear
    out_ready = 1'b0;
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    push(8'h04, 1'b1);
    push(8'h05, 1'b0);
    read_chk("ovf_status", ST, 32'h26);
    drive(1'b1, ST, 32'hFFFF_FFFB);
    check("ovf_keep_wrong_bit", rdata, 32'h26);
    tick();
    read_chk("ovf_still_set", ST, 32'h26);
    drive(1'b1, ST, 32'h4);
    check("ovf_clr_old", rdata, 32'h26);
    tick();
    read_chk("ovf_cleared", ST, 32'h22);

    // Full FIFO push with simultaneous pop
    out_ready = 1'b1;
    push(8'h55, 1'b1);
    out_ready = 1'b0;
    read_chk("full_pushpop_status", ST, 32'h22);
    out_ready = 1'b1;
    idle_cycles(4);
    read_chk("full_drained", ST, 32'h1);

    // Reset mid-stream
    out_ready = 1'b0;
    push(8'h81, 1'b1);
    push(8'h82, 1'b1);
    clr = 1'b1;
    exp_q.delete();
    drive(1'b1, 32'h20, 32'hAAAA_AAAA);
    tick();
    clr = 1'b0;
    drive(1'b0, CYC, 32'h0);
    check("midrst_cycle", rdata, 32'h0);
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    tick();
    read_chk("midrst_ram", 32'h10, 32'h0);
    read_chk("midrst_we_ignored", 32'h20, 32'h0);
    read_chk("midrst_status", ST, 32'h1);
    out_ready = 1'b1;
    idle_cycles(2);

    check("queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 The block SHALL take parameter RAM_AW, default 6, as the word-address width of the RAM (2^RAM_AW words).
REQ-002 The block SHALL take parameter FIFO_AW, default 2, as the TX FIFO pointer width (2^FIFO_AW entries).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port addr  input  32  CPU byte address; addr[1:0] ignored.
REQ-006 The block SHALL have port wdata  input  32  CPU store data.
REQ-007 The block SHALL have port we  input  1  CPU store strobe.
REQ-008 The block SHALL have port rdata  output  32  load data, combinational from addr.
REQ-009 The block SHALL have port out_data  output  8  TX FIFO head byte.
REQ-010 The block SHALL have port out_valid  output  1  FIFO non-empty.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts the head byte.

Function
REQ-012 The block SHALL map the RAM at addr[31:RAM_AW+2]==0, word index addr[RAM_AW+1:2].
REQ-013 The block SHALL map TXDATA at 0xF000_0000, STATUS at 0xF000_0004 and CYCLE at 0xF000_0008.
REQ-014 The block SHALL return 0 on rdata for unmapped addresses and SHALL ignore writes to them.
REQ-015 RAM reads SHALL be combinational, same cycle; RAM writes SHALL commit at the clk edge where we=1.
REQ-016 A read to the address being written SHALL return the old word until the edge.
REQ-017 A write to TXDATA SHALL push wdata[7:0] into the FIFO; a TXDATA read SHALL return 0.
REQ-018 STATUS read SHALL return {26'b0, count[2:0], ovf, full, empty}, with count in 0..4.
REQ-019 A STATUS write with wdata[2]=1 SHALL clear ovf; other STATUS write bits SHALL be ignored.
REQ-020 CYCLE SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-021 A CYCLE write SHALL load wdata, so the next-cycle value equals wdata; a read in the write cycle SHALL return the old value.
REQ-022 A pop SHALL occur at the edge where out_valid=1 and out_ready=1; out_data SHALL be the head entry, or 0 when empty.
REQ-023 A push while not full SHALL be accepted; out_valid SHALL rise the cycle after a push into an empty FIFO (1-cycle latency).
REQ-024 A push while full with no pop in the same cycle SHALL be dropped and SHALL set sticky ovf.
REQ-025 A push while full with a simultaneous pop SHALL be accepted, leaving count=4 and ovf unchanged.
REQ-026 A push and pop in the same cycle while non-empty SHALL leave count unchanged and keep FIFO order.
REQ-027 A push on empty with out_ready=1 SHALL NOT bypass: the byte SHALL appear the following cycle.
REQ-028 The read and write pointers SHALL wrap modulo 2^FIFO_AW; count SHALL be held as a separate FIFO_AW+1-bit counter.
REQ-029 A ovf-clear and a dropping push in the same cycle SHALL leave ovf=1 (set wins).

Reset
REQ-030 While clr=1 at an edge, the block SHALL zero all RAM words, CYCLE, both FIFO pointers, count and ovf, and SHALL ignore we.
REQ-031 After reset, out_valid=0, out_data=0, and rdata SHALL reflect the zeroed state.
REQ-032 A reset asserted mid-stream SHALL discard all FIFO contents with no pop reported.

Verification
REQ-033 RAM scenario: write 0xDEADBEEF to 0x0000_0010 -> same-cycle rdata=old 0; next cycle rdata=0xDEADBEEF; 0x0000_0100 reads 0.
REQ-034 FIFO order scenario: push 0x41,0x42,0x43 with out_ready=0 -> STATUS=0x18; then out_ready=1 -> 0x41,0x42,0x43 on consecutive cycles, then out_valid=0.
REQ-035 Overflow scenario: push 5 bytes with out_ready=0 -> count=4, ovf=1, STATUS=0x26, 5th byte absent; STATUS write 0x4 -> ovf=0.
REQ-036 Full push+pop scenario: FIFO full, push 0x55 with out_ready=1 -> count stays 4, ovf=0, 0x55 is the last byte out.
REQ-037 CYCLE scenario: write 0xFFFF_FFFE -> subsequent reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
REQ-038 Reset scenario: clr pulse with 2 bytes queued and RAM nonzero -> out_valid=0, CYCLE=0, RAM reads 0, STATUS=0x01.
